// File: rtl/im_fold_sequencer.sv
// rtl/im_fold_sequencer.sv - streams NUM_FOLDS item-memory fold words per request through a 2-entry output FIFO
// Optional write port enabled by defining IM_WRITE_EN.
module im_fold_sequencer #(
    parameter int FOLD_WIDTH      = 500,
    parameter int SRAM_ADDR_WIDTH = 7,
    parameter int NUM_FOLDS       = 20,
    localparam int IDX_W          = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] req_base_addr,
    output logic [SRAM_ADDR_WIDTH-1:0] im_addr,
    output logic                       we,
    input  logic [FOLD_WIDTH-1:0]      im_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FOLD_WIDTH-1:0]      out_data,
    output logic [IDX_W-1:0]           out_fold_idx,
    output logic                       out_last,
    output logic                       busy
`ifdef IM_WRITE_EN
    ,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [FOLD_WIDTH-1:0]      wr_data,
    output logic [FOLD_WIDTH-1:0]      im_din
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FOLDS - 1);

    state_t                     state_q, state_d;
    logic [SRAM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [IDX_W-1:0]           fold_cnt_q, fold_cnt_d;
    logic [SRAM_ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
    logic                       we_q, we_d;
    logic                       inflight_q, inflight_d;
    logic [IDX_W-1:0]           tag_idx_q, tag_idx_d;
    logic [FOLD_WIDTH-1:0]      f_data_q [2];
    logic [FOLD_WIDTH-1:0]      f_data_d [2];
    logic [IDX_W-1:0]           f_idx_q [2];
    logic [IDX_W-1:0]           f_idx_d [2];
    logic                       f_last_q [2];
    logic                       f_last_d [2];
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                 count_q, count_d;
    logic                       push, pop, issue;
    logic [2:0]                 occ;
`ifdef IM_WRITE_EN
    logic [FOLD_WIDTH-1:0]      im_din_q, im_din_d;
`endif

    assign out_valid    = (count_q != 2'd0);
    assign out_data     = out_valid ? f_data_q[rd_ptr_q] : '0;
    assign out_fold_idx = out_valid ? f_idx_q[rd_ptr_q] : '0;
    assign out_last     = out_valid & f_last_q[rd_ptr_q];
    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign im_addr      = im_addr_q;
    assign we           = we_q;
`ifdef IM_WRITE_EN
    assign wr_ready     = (state_q == IDLE);
    assign im_din       = im_din_q;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        fold_cnt_d = fold_cnt_q;
        im_addr_d  = im_addr_q;
        we_d       = 1'b0;
        inflight_d = 1'b0;
        tag_idx_d  = tag_idx_q;
        f_data_d   = f_data_q;
        f_idx_d    = f_idx_q;
        f_last_d   = f_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
`ifdef IM_WRITE_EN
        im_din_d   = im_din_q;
`endif
        pop   = out_valid & out_ready;
        push  = inflight_q;
        // Slots already spoken for after this edge; keeps the FIFO from overflowing.
        occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue = (state_q == READ) && (occ < 3'd2);

        if (push) begin
            f_data_d[wr_ptr_q] = im_dout;
            f_idx_d[wr_ptr_q]  = tag_idx_q;
            f_last_d[wr_ptr_q] = (tag_idx_q == LAST_IDX);
            wr_ptr_d           = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);

        case (state_q)
            IDLE: begin
`ifdef IM_WRITE_EN
                if (wr_valid) begin
                    im_addr_d = wr_addr;
                    im_din_d  = wr_data;
                    we_d      = 1'b1;
                    state_d   = WRITE;
                end else
`endif
                if (req_valid) begin
                    base_d     = req_base_addr;
                    fold_cnt_d = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (issue) begin
                    im_addr_d  = base_q + SRAM_ADDR_WIDTH'(fold_cnt_q);
                    inflight_d = 1'b1;
                    tag_idx_d  = fold_cnt_q;
                    fold_cnt_d = fold_cnt_q + IDX_W'(1);
                    if (fold_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((count_d == 2'd0) && !inflight_d) begin
                    state_d = IDLE;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            fold_cnt_q <= '0;
            im_addr_q  <= '0;
            we_q       <= 1'b0;
            inflight_q <= 1'b0;
            tag_idx_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
`ifdef IM_WRITE_EN
            im_din_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            fold_cnt_q <= fold_cnt_d;
            im_addr_q  <= im_addr_d;
            we_q       <= we_d;
            inflight_q <= inflight_d;
            tag_idx_q  <= tag_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef IM_WRITE_EN
            im_din_q   <= im_din_d;
`endif
        end
    end

    // Entry storage needs no reset: out_* are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        f_data_q <= f_data_d;
        f_idx_q  <= f_idx_d;
        f_last_q <= f_last_d;
    end

endmodule

// File: tb/tb_im_fold_sequencer.sv
// tb/tb_im_fold_sequencer.sv - directed bench with a fold-stream reference model for three im_fold_sequencer configurations
module tb_im_fold_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic              out_ready;
    logic [6:0]        base_addr;
    logic              req_valid [3];
    logic              req_ready [3];
    logic              we [3];
    logic              out_valid [3];
    logic              out_last [3];
    logic              busy [3];
    logic [6:0]        im_addr [3];
    logic [499:0]      im_dout [3];
    logic [499:0]      out_data [3];
    logic [4:0]        idx0;
    logic [1:0]        idx1;
    logic [0:0]        idx2;
    logic [4:0]        fidx [3];
    logic [499:0]      mem [128];
`ifdef IM_WRITE_EN
    logic              wr_valid [3];
    logic              wr_ready [3];
    logic [6:0]        wr_addr;
    logic [499:0]      wr_data;
    logic [499:0]      im_din [3];
`endif

    int  n_vec = 0;
    int  n_err = 0;
    bit  armed = 1'b0;
    bit  active [3];
    bit  wr_phase [3];
    bit  prev_stall [3];
    int  exp_base [3];
    int  exp_next [3];
    logic [499:0] prev_data [3];

    always #5 clk = ~clk;

    assign im_dout[0] = mem[im_addr[0]];
    assign im_dout[1] = mem[im_addr[1]];
    assign im_dout[2] = mem[im_addr[2]];
    assign fidx[0] = idx0;
    assign fidx[1] = {3'b0, idx1};
    assign fidx[2] = {4'b0, idx2};

    im_fold_sequencer #(.FOLD_WIDTH(500), .SRAM_ADDR_WIDTH(7), .NUM_FOLDS(20)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_base_addr(base_addr), .im_addr(im_addr[0]), .we(we[0]), .im_dout(im_dout[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_fold_idx(idx0), .out_last(out_last[0]), .busy(busy[0])
`ifdef IM_WRITE_EN
        , .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr),
        .wr_data(wr_data), .im_din(im_din[0])
`endif
    );

    im_fold_sequencer #(.FOLD_WIDTH(500), .SRAM_ADDR_WIDTH(7), .NUM_FOLDS(4)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_base_addr(base_addr), .im_addr(im_addr[1]), .we(we[1]), .im_dout(im_dout[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_fold_idx(idx1), .out_last(out_last[1]), .busy(busy[1])
`ifdef IM_WRITE_EN
        , .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr),
        .wr_data(wr_data), .im_din(im_din[1])
`endif
    );

    im_fold_sequencer #(.FOLD_WIDTH(500), .SRAM_ADDR_WIDTH(7), .NUM_FOLDS(1)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_base_addr(base_addr), .im_addr(im_addr[2]), .we(we[2]), .im_dout(im_dout[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
        .out_fold_idx(idx2), .out_last(out_last[2]), .busy(busy[2])
`ifdef IM_WRITE_EN
        , .wr_valid(wr_valid[2]), .wr_ready(wr_ready[2]), .wr_addr(wr_addr),
        .wr_data(wr_data), .im_din(im_din[2])
`endif
    );

    function automatic int nf_of(input int k);
        return (k == 0) ? 20 : (k == 1) ? 4 : 1;
    endfunction

    function automatic logic [499:0] fold_word(input int a);
        logic [499:0] w;
        w = '0;
        for (int i = 0; i < 50; i++) w[i*10 +: 10] = 10'(a * 37 + i * 11 + 3);
        return w;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int k, input logic [6:0] b);
        base_addr    = b;
        req_valid[k] = 1'b1;
        tick;
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        for (int c = 0; c < budget && active[k]; c++) tick;
        chk($sformatf("u%0d drain_timeout", k), active[k], 1'b0);
    endtask

    task automatic check_reset(input int k);
        chk($sformatf("u%0d rst req_ready", k), req_ready[k], 1'b1);
        chk($sformatf("u%0d rst busy", k), busy[k], 1'b0);
        chk($sformatf("u%0d rst out_valid", k), out_valid[k], 1'b0);
        chk($sformatf("u%0d rst out_last", k), out_last[k], 1'b0);
        chk($sformatf("u%0d rst out_fold_idx", k), fidx[k], 0);
        chk($sformatf("u%0d rst out_data", k), out_data[k], 0);
        chk($sformatf("u%0d rst im_addr", k), im_addr[k], 0);
        chk($sformatf("u%0d rst we", k), we[k], 1'b0);
    endtask

    // Reference: an accepted request owes folds base+0 .. base+NF-1 in order; the block is idle
    // exactly when every owed fold has been handed over and no write is in progress.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                bit idle_now;
                bit wr_req;
                idle_now = !active[k] && !wr_phase[k];
                wr_req = 1'b0;
`ifdef IM_WRITE_EN
                wr_req = wr_valid[k];
                chk($sformatf("u%0d wr_ready", k), wr_ready[k], idle_now);
`endif
                chk($sformatf("u%0d req_ready", k), req_ready[k], idle_now);
                chk($sformatf("u%0d busy", k), busy[k], !idle_now);
                chk($sformatf("u%0d we", k), we[k], wr_phase[k]);
                if (prev_stall[k]) begin
                    chk($sformatf("u%0d stall valid", k), out_valid[k], 1'b1);
                    chk($sformatf("u%0d stall data", k), out_data[k], prev_data[k]);
                end
                if (out_valid[k]) begin
                    chk($sformatf("u%0d unexpected beat", k), active[k], 1'b1);
                    if (active[k]) begin
                        chk($sformatf("u%0d data", k), out_data[k],
                            fold_word((exp_base[k] + exp_next[k]) % 128));
                        chk($sformatf("u%0d fold_idx", k), fidx[k], exp_next[k]);
                        chk($sformatf("u%0d last", k), out_last[k], exp_next[k] == nf_of(k) - 1);
                    end
                end
                prev_stall[k] = out_valid[k] && !out_ready;
                prev_data[k]  = out_data[k];
                if (out_valid[k] && out_ready && active[k]) begin
                    exp_next[k]++;
                    if (exp_next[k] == nf_of(k)) active[k] = 1'b0;
                end
                if (wr_phase[k]) begin
                    wr_phase[k] = 1'b0;
                end else if (idle_now && !rst) begin
                    if (wr_req) begin
                        wr_phase[k] = 1'b1;
                    end else if (req_valid[k]) begin
                        active[k]   = 1'b1;
                        exp_base[k] = int'(base_addr);
                        exp_next[k] = 0;
                    end
                end
                if (rst) begin
                    active[k]     = 1'b0;
                    wr_phase[k]   = 1'b0;
                    prev_stall[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [6:0] ea;
        rst       = 1'b1;
        out_ready = 1'b1;
        base_addr = '0;
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
`ifdef IM_WRITE_EN
        for (int k = 0; k < 3; k++) wr_valid[k] = 1'b0;
        wr_addr = '0;
        wr_data = '0;
`endif
        for (int a = 0; a < 128; a++) mem[a] = fold_word(a);
        repeat (3) tick;
        for (int k = 0; k < 3; k++) check_reset(k);
        rst   = 1'b0;
        armed = 1'b1;
        tick;

        // Full 20-fold transfer from base 0 with the sink always ready.
        start(0, 7'h00);
        for (int j = 0; j < 20; j++) begin
            tick;
            chk("t1 im_addr", im_addr[0], j);
            if (j == 0) chk("t1 no early beat", out_valid[0], 1'b0);
            if (j == 1) begin
                chk("t1 first beat valid", out_valid[0], 1'b1);
                chk("t1 first beat idx", fidx[0], 0);
            end
        end
        tick;
        chk("t1 last beat valid", out_valid[0], 1'b1);
        chk("t1 last beat idx", fidx[0], 19);
        chk("t1 last beat flag", out_last[0], 1'b1);
        chk("t1 still busy", req_ready[0], 1'b0);
        tick;
        chk("t1 ready after 22", req_ready[0], 1'b1);
        tick;

        // Address wrap-around at the top of the item memory.
        start(1, 7'h7E);
        for (int j = 0; j < 4; j++) begin
            tick;
            ea = 7'h7E + 7'(j);
            chk("t2 im_addr wrap", im_addr[1], ea);
        end
        wait_idle(1, 20);
        tick;

        // Back-pressure: random ready with a 10-cycle hold-off mid-stream.
        start(0, 7'h10);
        for (int c = 0; c < 300 && active[0]; c++) begin
            out_ready = (c >= 8 && c < 18) ? 1'b0 : 1'($urandom_range(0, 1));
            tick;
        end
        chk("t3 stall drain", active[0], 1'b0);
        out_ready = 1'b1;
        tick;

        // Reset one cycle after fold 3 is issued.
        start(0, 7'h00);
        repeat (4) tick;
        chk("t4 fold3 issued", im_addr[0], 3);
        rst = 1'b1;
        tick;
        check_reset(0);
        rst = 1'b0;
        tick;
        chk("t4 no stale beat", out_valid[0], 1'b0);
        chk("t4 idle", req_ready[0], 1'b1);
        start(0, 7'h05);
        repeat (2) tick;
        chk("t4 restart valid", out_valid[0], 1'b1);
        chk("t4 restart idx", fidx[0], 0);
        chk("t4 restart data", out_data[0], fold_word(5));
        wait_idle(0, 40);
        tick;

        // Requests while busy are dropped, not queued.
        start(0, 7'h20);
        repeat (3) tick;
        base_addr    = 7'h40;
        req_valid[0] = 1'b1;
        repeat (5) tick;
        req_valid[0] = 1'b0;
        base_addr    = '0;
        wait_idle(0, 40);
        tick;
        chk("t5 idle after ignore", req_ready[0], 1'b1);

        // Single-fold configuration.
        start(2, 7'h33);
        tick;
        chk("t6 no early beat", out_valid[2], 1'b0);
        tick;
        chk("t6 beat valid", out_valid[2], 1'b1);
        chk("t6 beat last", out_last[2], 1'b1);
        chk("t6 beat idx", fidx[2], 0);
        chk("t6 beat data", out_data[2], fold_word(8'h33));
        tick;
        chk("t6 done valid", out_valid[2], 1'b0);
        chk("t6 done ready", req_ready[2], 1'b1);

`ifdef IM_WRITE_EN
        // Simultaneous write and read request: write first, then the read.
        tick;
        wr_addr      = 7'h05;
        wr_data      = fold_word(99);
        wr_valid[1]  = 1'b1;
        base_addr    = 7'h10;
        req_valid[1] = 1'b1;
        tick;
        wr_valid[1]  = 1'b0;
        chk("t7 we", we[1], 1'b1);
        chk("t7 wr im_addr", im_addr[1], 5);
        chk("t7 im_din", im_din[1], fold_word(99));
        chk("t7 req held off", req_ready[1], 1'b0);
        tick;
        chk("t7 we one cycle", we[1], 1'b0);
        chk("t7 idle after write", req_ready[1], 1'b1);
        tick;
        req_valid[1] = 1'b0;
        chk("t7 read accepted", busy[1], 1'b1);
        wait_idle(1, 20);
`endif

        repeat (2) tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
